// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the pixel-stream FIFOs.
// The default width and depth are also used by the filter tops.
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH = 8;
    localparam int FIFO_DEFAULT_DEPTH = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_fwft_if.sv
// Pixel-stream handshake between a producer/consumer pair and a FWFT FIFO.
// The master side drives requests and data, and the FIFO (slave) drives status.
interface fifo_fwft_if #(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int FIFO_BUFFER_SIZE = 16
) ();

    localparam int CW = $clog2(FIFO_BUFFER_SIZE) + 1;

    logic                       wr_en;
    logic [FIFO_DATA_WIDTH-1:0] din;
    logic                       full;
    logic                       almost_full;
    logic                       rd_en;
    logic [FIFO_DATA_WIDTH-1:0] dout;
    logic                       empty;
    logic [CW-1:0]              count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output wr_en, din, rd_en,
        input  full, almost_full, dout, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, almost_full, dout, empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for the FWFT FIFO: one synchronous write port and one asynchronous read port.
// The contents are deliberately left unreset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH  = FIFO_DEFAULT_WIDTH,
    parameter int FIFO_BUFFER_SIZE = FIFO_DEFAULT_DEPTH,
    localparam int AW = ptr_width(FIFO_BUFFER_SIZE)
) (
    input  logic                       clock,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [FIFO_DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]              raddr,
    output logic [FIFO_DATA_WIDTH-1:0] rdata
);

    logic [FIFO_DATA_WIDTH-1:0] mem_q [FIFO_BUFFER_SIZE];

    // Write port
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: pointers, occupancy, status flags and head-word gating.
// Status flags are registered decodes of the next occupancy, so they are exact one edge after each change.
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH  = FIFO_DEFAULT_WIDTH,
    parameter int FIFO_BUFFER_SIZE = FIFO_DEFAULT_DEPTH,
    parameter int ALMOST_FULL_LVL  = FIFO_BUFFER_SIZE - 2
) (
    input logic        clock,
    input logic        reset,
    fifo_fwft_if.slave bus
);

    localparam int AW = ptr_width(FIFO_BUFFER_SIZE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_BUFFER_SIZE);
    localparam logic [CW-1:0] AFULL_C = CW'(ALMOST_FULL_LVL);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       full_q, full_d;
    logic                       empty_q, empty_d;
    logic                       afull_q, afull_d;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;
    logic                       rd_ok_s;
    logic                       wr_ok_s;
    logic [FIFO_DATA_WIDTH-1:0] mem_rdata_s;

    // Accept decisions; a write into a full FIFO rides on a same-cycle pop
    always_comb begin
        rd_ok_s = bus.rd_en & (count_q != ZERO_C);
        wr_ok_s = bus.wr_en & ((count_q != DEPTH_C) | rd_ok_s);
    end

    // Next pointers and occupancy
    always_comb begin
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Status decodes of the next occupancy and sticky error flags
    always_comb begin
        full_d      = (count_d == DEPTH_C);
        empty_d     = (count_d == ZERO_C);
        afull_d     = (count_d >= AFULL_C);
        overflow_d  = overflow_q  | (bus.wr_en & ~wr_ok_s);
        underflow_d = underflow_q | (bus.rd_en & ~rd_ok_s);
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= ZERO_C;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .FIFO_DATA_WIDTH  (FIFO_DATA_WIDTH),
        .FIFO_BUFFER_SIZE (FIFO_BUFFER_SIZE)
    ) u_mem (
        .clock (clock),
        .we    (wr_ok_s & ~reset),
        .waddr (wr_ptr_q),
        .wdata (bus.din),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata_s)
    );

    // The head word is only meaningful while non-empty
    always_comb begin
        if (empty_q) begin
            bus.dout = {FIFO_DATA_WIDTH{1'b0}};
        end else begin
            bus.dout = mem_rdata_s;
        end
    end

    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.almost_full = afull_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: doc/fifo_fwft.md
Name: fifo_fwft

Overview:
- Synchronous first-word-fall-through FIFO: the storage end of the pixel-stream handshake used by the edge-detect filters.
- Accepts writes on wr_en/full/din and serves reads on rd_en/empty/dout.
- The head word is visible on dout whenever empty=0. A consumer that asserts rd_en captures dout in that same cycle.
- Sits between the image source, the filter stages and the image sink. One instance per stream link.

Parameters:
- FIFO_DATA_WIDTH, 8, bits per word (8 for grayscale pixels, 24 for RGB).
- FIFO_BUFFER_SIZE, 16, depth in words; must be a power of two, at least 2.
- ALMOST_FULL_LVL, FIFO_BUFFER_SIZE-2, occupancy at or above which almost_full asserts.

Ports:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high
- wr_en  in  1  write request
- din  in  FIFO_DATA_WIDTH  write data
- full  out  1  occupancy equals FIFO_BUFFER_SIZE
- almost_full  out  1  occupancy >= ALMOST_FULL_LVL
- rd_en  in  1  read (pop) request
- dout  out  FIFO_DATA_WIDTH  head word, valid while empty=0
- empty  out  1  occupancy equals 0
- count  out  $clog2(FIFO_BUFFER_SIZE)+1  current occupancy
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
- Storage contents are not reset.
- Reset asserted mid-stream discards all contents on that edge. A wr_en or rd_en in the reset cycle is ignored.
- Accept rules, evaluated on each rising edge:
  - rd_ok = rd_en & (count != 0).
  - wr_ok = wr_en & ((count != FIFO_BUFFER_SIZE) | rd_ok).
  - When full, a write is accepted only if a read is accepted in the same cycle.
- On wr_ok: mem[wr_ptr] <= din; wr_ptr increments modulo FIFO_BUFFER_SIZE (natural wrap of a log2-wide pointer).
- On rd_ok: rd_ptr increments modulo FIFO_BUFFER_SIZE.
- count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - unchanged when both or neither occur.
- full, empty and almost_full are registered decodes of the next count. They are exact, with no pessimism: each reflects the new occupancy in the cycle after the edge that changed it.
- dout is combinational from mem[rd_ptr] gated by !empty (dout=0 when empty).
- Write-to-read latency: a word written into an empty FIFO on edge N appears on dout with empty=0 after edge N. No bypass: din never reaches dout in the same cycle.
- Read latency: after a pop on edge N, the next word is on dout after edge N; there are no bubbles at full throughput.
- Simultaneous write and read when count=0: write accepted, read rejected, underflow set.
- Error flags:
  - overflow sets on wr_en & !wr_ok.
  - underflow sets on rd_en & !rd_ok.
  - Both stay set until reset; the rejected operation has no other effect.
- Sustained one write plus one read per cycle at any occupancy from 1 to FIFO_BUFFER_SIZE leaves count constant.

Decomposition:
- fifo_pkg holds:
  - the function ptr_width(depth) = $clog2(depth);
  - the default depth and width constants shared with the filter tops.
- Sub-module fifo_mem:
  - FIFO_DATA_WIDTH x FIFO_BUFFER_SIZE register array;
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr, rdata).
- fifo_fwft holds the pointers, count, flag logic and dout gating.

Test Plan (width 8, depth 16):
- Reset, then idle: empty=1, full=0, count=0, dout=0. Then rd_en=1 for one cycle -> underflow=1, count stays 0.
- Write 0x11, 0x22, 0x33 on consecutive cycles, rd_en=0:
  - empty=0 one edge after the first write, with dout=0x11;
  - count=3 after the third edge.
  - Then pop three times -> dout 0x11, 0x22, 0x33 in order, then empty=1.
- Write 0x00..0x0F (16 words):
  - almost_full=1 when count=14;
  - full=1 at count=16.
  - A 17th write of 0xAA -> rejected, overflow=1, count=16, dout still 0x00.
- Full FIFO, wr_en=1 din=0xBB with rd_en=1 in the same cycle:
  - count stays 16, full stays 1, dout becomes 0x01, overflow not newly set.
  - After 16 further pops, the last word read is 0xBB.
- Pointer wrap: stream 100 words (0x00..0x63) with wr_en and rd_en both asserted every cycle after the first write -> the data read matches the data written in order, count stays 1, no flags set.
- Reset mid-stream with count=7 and overflow=1, wr_en=1 on the reset cycle -> after the edge count=0, empty=1, overflow=0. The next write 0x5A appears on dout one edge later.
